wr_ingress_ctrl: RTL and testbench
==================================

WR_INGRESS_CTRL -- requirements
Module: wr_ingress_ctrl

Interface
REQ-001 Parameter DATA, default 8, payload width in bits.
REQ-002 Parameter ADDR, default 4, FIFO address width; pointers are ADDR+1 bits.
REQ-003 wr_clk  input  1  write-domain clock; all state rises on posedge wr_clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  producer has a word on s_data.
REQ-006 s_data  input  DATA  producer payload.
REQ-007 s_ready  output  1  block can accept a word this cycle.
REQ-008 full_flag  input  1  registered FIFO-full indication from the write-side full logic.
REQ-009 gr_rd_ptr  input  ADDR+1  Gray-coded read pointer, read-clock domain.
REQ-010 wr_en  output  1  write strobe to FIFO memory and write-pointer logic.
REQ-011 wr_data  output  DATA  word to write when wr_en is high.
REQ-012 sync_rd_ptr  output  ADDR+1  gr_rd_ptr resynchronised to wr_clk.
REQ-013 stall_cnt  output  16  full-stall cycle count; present only under WR_INGRESS_STATS_EN.

Function
REQ-014 The block SHALL hold a 2-entry in-order skid buffer with states EMPTY, ONE, TWO.
REQ-015 accept = s_valid && s_ready; pop = wr_en.
REQ-016 wr_en SHALL be (state != EMPTY) && !full_flag, combinational from registered state and full_flag only.
REQ-017 wr_data SHALL be the oldest buffered entry; when state is EMPTY, wr_data holds its last value.
REQ-018 s_ready SHALL be a register loaded each cycle with (next_state != TWO); no combinational path from s_valid or full_flag to s_ready.
REQ-019 Transitions: EMPTY+accept->ONE; ONE+accept+!pop->TWO; ONE+pop+!accept->EMPTY; ONE+accept+pop->ONE, with the new word becoming head; TWO+pop->ONE; all other cases hold.
REQ-020 In TWO, s_ready is low, so accept cannot occur; s_valid is ignored.
REQ-021 Latency: a word accepted at edge N SHALL be presented with wr_en high from cycle N+1 if full_flag is low and it is the head.
REQ-022 While full_flag is high, no pop occurs, buffered words are retained unchanged, and order is preserved.
REQ-023 Words SHALL leave in acceptance order, with no loss or duplication, under any full_flag pattern.
REQ-024 sync_rd_ptr SHALL be the output of a 2-flop synchronizer on gr_rd_ptr, giving 2 wr_clk edges of latency, with no logic between the flops.
REQ-025 Throughput: with full_flag low and s_valid continuously high, one word is written per cycle.

Reset
REQ-026 While rst is low: state EMPTY, s_ready 0, wr_en 0, wr_data 0, both synchronizer stages 0, stall_cnt 0.
REQ-027 s_ready SHALL rise on the first wr_clk edge after rst deasserts.
REQ-028 Reset asserted mid-operation SHALL discard buffered words immediately and asynchronously.

Configuration
REQ-029 Macro WR_INGRESS_STATS_EN defined: stall_cnt increments each cycle with (state != EMPTY) && full_flag, saturating at 16'hFFFF.
REQ-030 Macro WR_INGRESS_STATS_EN undefined: the stall_cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-031 Reset release, s_valid=1, s_data=0x11, full_flag=0 -> s_ready=1 one edge after release; next cycle wr_en=1, wr_data=0x11.
REQ-032 Stream 0x01..0x08 back-to-back with full_flag=0 -> wr_en high 8 consecutive cycles, data 0x01..0x08 in order, s_ready never drops.
REQ-033 full_flag=1 while sending 0xA0, 0xA1, 0xA2 -> s_ready low after 2 accepts, 0xA2 held by producer; full_flag=0 -> writes 0xA0, 0xA1, 0xA2 in order.
REQ-034 gr_rd_ptr steps 5'b00000->5'b00001 -> sync_rd_ptr shows 5'b00001 exactly 2 edges later.
REQ-035 With macro defined, buffer occupied and full_flag=1 for 10 cycles -> stall_cnt=10; force 70000 stall cycles -> stall_cnt=16'hFFFF.
REQ-036 rst pulsed low while state is TWO -> wr_en and s_ready go 0 immediately; after release, no stale words are written.

Source files
------------

// File: rtl/wr_ingress_ctrl_if.sv
// Write-side ingress bundle: producer handshake, FIFO write strobe and read-pointer sync.
// The stall_cnt signal exists only when WR_INGRESS_STATS_EN is defined.
interface wr_ingress_ctrl_if #(
  parameter int DATA = 8,
  parameter int ADDR = 4
);
  logic            s_valid;
  logic [DATA-1:0] s_data;
  logic            s_ready;
  logic            full_flag;
  logic [ADDR:0]   gr_rd_ptr;
  logic            wr_en;
  logic [DATA-1:0] wr_data;
  logic [ADDR:0]   sync_rd_ptr;
`ifdef WR_INGRESS_STATS_EN
  logic [15:0]     stall_cnt;
`endif

  // Environment side: producer, full logic and read-domain pointer source.
  modport master (
    output s_valid,
    output s_data,
    output full_flag,
    output gr_rd_ptr,
    input  s_ready,
    input  wr_en,
    input  wr_data,
    input  sync_rd_ptr
`ifdef WR_INGRESS_STATS_EN
    ,
    input  stall_cnt
`endif
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  full_flag,
    input  gr_rd_ptr,
    output s_ready,
    output wr_en,
    output wr_data,
    output sync_rd_ptr
`ifdef WR_INGRESS_STATS_EN
    ,
    output stall_cnt
`endif
  );
endinterface

// File: rtl/wr_ingress_ctrl.sv
// FIFO write-side ingress: 2-entry skid buffer feeding wr_en/wr_data, plus read-pointer synchronizer.
// Optional full-stall counter enabled by defining WR_INGRESS_STATS_EN.
module wr_ingress_ctrl #(
  parameter int DATA = 8,
  parameter int ADDR = 4
) (
  input  logic             wr_clk,
  input  logic             rst,
  wr_ingress_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_ready;
  logic [DATA-1:0] r_head;
  logic [DATA-1:0] r_tail;
  logic [ADDR:0]   r_sync_meta;
  logic [ADDR:0]   r_sync_out;

  logic            w_accept;
  logic            w_pop;
  logic            w_load_head_in;
  logic            w_load_tail_in;
  logic            w_head_from_tail;

  // wr_en depends only on registered occupancy and full_flag, never on s_valid.
  assign w_pop    = (r_state != ST_EMPTY) && !bus.full_flag;
  assign w_accept = bus.s_valid && r_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_head_in   = 1'b0;
    w_load_tail_in   = 1'b0;
    w_head_from_tail = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next_state   = ST_ONE;
          w_load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_pop) begin
          w_next_state   = ST_TWO;
          w_load_tail_in = 1'b1;
        end else if (w_accept && w_pop) begin
          w_next_state   = ST_ONE;
          w_load_head_in = 1'b1;
        end else if (w_pop) begin
          w_next_state   = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // s_ready is low here, so only a pop can move the buffer.
        if (w_pop) begin
          w_next_state     = ST_ONE;
          w_head_from_tail = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_next_state != ST_TWO);
    end
  end

  // Head is left untouched on the final pop so wr_data holds its last value while empty.
  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head <= bus.s_data;
      end else if (w_head_from_tail) begin
        r_head <= r_tail;
      end
      if (w_load_tail_in) begin
        r_tail <= bus.s_data;
      end
    end
  end

  // Plain two-flop synchronizer; the Gray code guarantees at most one bit is in flight.
  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      r_sync_meta <= '0;
      r_sync_out  <= '0;
    end else begin
      r_sync_meta <= bus.gr_rd_ptr;
      r_sync_out  <= r_sync_meta;
    end
  end

  assign bus.s_ready     = r_ready;
  assign bus.wr_en       = w_pop;
  assign bus.wr_data     = r_head;
  assign bus.sync_rd_ptr = r_sync_out;

`ifdef WR_INGRESS_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if ((r_state != ST_EMPTY) && bus.full_flag && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Scoreboard bench for wr_ingress_ctrl: accepted words are queued by the driver and
// checked in order by a negedge monitor against an occupancy-level model.
module tb_wr_ingress_ctrl;

  logic wr_clk;
  logic rst;

  wr_ingress_ctrl_if #(.DATA(8), .ADDR(4)) bus ();

  wr_ingress_ctrl #(.DATA(8), .ADDR(4)) dut (
    .wr_clk (wr_clk),
    .rst    (rst),
    .bus    (bus)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_writes = 0;
  int         exp_stall = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_wr = 8'h00;
  logic       last_acc = 1'b0;
  logic [4:0] ptr_h1;
  logic [4:0] ptr_h2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Pointer value seen two edges ago is what the synchronizer must present.
  always @(posedge wr_clk or negedge rst) begin
    if (!rst) begin
      ptr_h1 <= '0;
      ptr_h2 <= '0;
    end else begin
      ptr_h1 <= bus.gr_rd_ptr;
      ptr_h2 <= ptr_h1;
    end
  end

  // Monitor: queue contents equal the words held during this cycle.
  always @(negedge wr_clk) begin
    if (!rst) begin
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      chk("rst_sync_rd_ptr", 32'(bus.sync_rd_ptr), 32'd0);
`ifdef WR_INGRESS_STATS_EN
      chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      exp_stall = 0;
`endif
    end else begin
      chk("s_ready", 32'(bus.s_ready), 32'(exp_q.size() < 2));
      chk("wr_en", 32'(bus.wr_en), 32'((exp_q.size() > 0) && !bus.full_flag));
      chk("sync_rd_ptr", 32'(bus.sync_rd_ptr), 32'(ptr_h2));
`ifdef WR_INGRESS_STATS_EN
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
      if ((exp_q.size() > 0) && bus.full_flag && (exp_stall < 65535)) exp_stall++;
`endif
      if (bus.wr_en && (exp_q.size() > 0)) begin
        chk("wr_data", 32'(bus.wr_data), 32'(exp_q[0]));
        last_wr = exp_q.pop_front();
        n_writes++;
      end else if (exp_q.size() == 0) begin
        chk("wr_data_hold", 32'(bus.wr_data), 32'(last_wr));
      end
    end
  end

  // One cycle of stimulus; inputs are changed only at posedge+1.
  task automatic step();
    logic acc;
    @(negedge wr_clk);
    acc = bus.s_valid && bus.s_ready && rst;
    @(posedge wr_clk);
    if (acc) exp_q.push_back(bus.s_data);
    last_acc = acc;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    exp_q.delete();
    last_wr   = 8'h00;
    exp_stall = 0;
    last_acc  = 1'b0;
    #1;
    chk("async_rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("async_rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("async_rst_wr_data", 32'(bus.wr_data), 32'd0);
    repeat (cycles) @(posedge wr_clk);
    @(negedge wr_clk);
    #1 rst = 1'b1;
    @(posedge wr_clk);
    #1;
    chk("ready_after_release", 32'(bus.s_ready), 32'd1);
  endtask

  task automatic drain();
    bus.s_valid   = 1'b0;
    bus.full_flag = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst           = 1'b1;
    bus.s_valid   = 1'b1;
    bus.s_data    = 8'h11;
    bus.full_flag = 1'b0;
    bus.gr_rd_ptr = 5'b00000;
    #1;

    // Reset release with a word already waiting.
    do_reset(2);
    step();
    bus.s_valid = 1'b0;
    chk("first_wr_en", 32'(bus.wr_en), 32'd1);
    chk("first_wr_data", 32'(bus.wr_data), 32'h11);
    step();
    step();

    // Back-to-back stream at full throughput.
    w0 = n_writes;
    for (int v = 1; v <= 8; v++) begin
      chk("stream_ready", 32'(bus.s_ready), 32'd1);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(v);
      step();
    end
    bus.s_valid = 1'b0;
    step();
    step();
    chk("stream_writes", 32'(n_writes - w0), 32'd8);

    // Back-pressure from full_flag fills both slots.
    w0 = n_writes;
    bus.full_flag = 1'b1;
    bus.s_valid   = 1'b1;
    bus.s_data    = 8'hA0;
    step();
    bus.s_data = 8'hA1;
    step();
    bus.s_data = 8'hA2;
    step();
    chk("bp_ready_low", 32'(bus.s_ready), 32'd0);
    step();
    step();
    chk("bp_no_write", 32'(n_writes - w0), 32'd0);
    bus.full_flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_acc) bus.s_valid = 1'b0;
    end
    chk("bp_writes", 32'(n_writes - w0), 32'd3);

    // Synchronizer latency.
    bus.gr_rd_ptr = 5'b00001;
    step();
    chk("sync_1_edge", 32'(bus.sync_rd_ptr), 32'd0);
    step();
    chk("sync_2_edges", 32'(bus.sync_rd_ptr), 32'd1);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      if (!bus.s_valid || last_acc) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_data  = 8'($urandom);
      end
      if ($urandom_range(0, 5) == 0) bus.full_flag = ~bus.full_flag;
      if ($urandom_range(0, 3) == 0) bus.gr_rd_ptr = 5'($urandom);
      step();
    end
    drain();

    // Reset while both slots are occupied discards them.
    bus.full_flag = 1'b1;
    bus.s_valid   = 1'b1;
    bus.s_data    = 8'hC3;
    step();
    bus.s_data = 8'hC4;
    step();
    chk("two_ready_low", 32'(bus.s_ready), 32'd0);
    bus.full_flag = 1'b0;
    #1;
    chk("two_wr_en", 32'(bus.wr_en), 32'd1);
    do_reset(2);
    w0 = n_writes;
    bus.s_valid = 1'b0;
    repeat (6) step();
    chk("no_stale_writes", 32'(n_writes - w0), 32'd0);

`ifdef WR_INGRESS_STATS_EN
    // Stall counting and saturation.
    do_reset(1);
    bus.full_flag = 1'b1;
    bus.s_valid   = 1'b1;
    bus.s_data    = 8'h55;
    step();
    bus.s_valid = 1'b0;
    repeat (10) step();
    chk("stall_10", 32'(bus.stall_cnt), 32'd10);
    repeat (70000) step();
    chk("stall_sat", 32'(bus.stall_cnt), 32'hFFFF);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
